// File: rtl/tlvds_tx_arbiter_if.sv
// Requester/pad bundle for tlvds_tx_arbiter.
//   en        : enables new grants
//   req       : per-requester request level, held until ack
//   data      : flattened payloads, requester k at [k*WIDTH +: WIDTH]
//   ack       : one-cycle one-hot grant pulse
//   busy      : high from grant until the guard gap ends
//   grant_id  : index of the last granted requester
//   tbuf_i    : to TLVDS_TBUF I
//   tbuf_oen  : to TLVDS_TBUF OEN (low = driving)
// master = requester side, slave = arbiter side.
interface tlvds_tx_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                    en;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   data;
    logic [NREQ-1:0]         ack;
    logic                    busy;
    logic [IDW-1:0]          grant_id;
    logic                    tbuf_i;
    logic                    tbuf_oen;

    modport master (
        output en, req, data,
        input  ack, busy, grant_id, tbuf_i, tbuf_oen
    );

    modport slave (
        input  en, req, data,
        output ack, busy, grant_id, tbuf_i, tbuf_oen
    );
endinterface

// File: rtl/tlvds_tx_arbiter.sv
// Round-robin scheduler sharing one TLVDS_TBUF differential pair between
// NREQ requesters. Each grant sends start bit, WIDTH data bits MSB-first,
// optional even parity bit, then GUARD tristated turnaround cycles.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset (pad tristates immediately)
//   bus   : tlvds_tx_arbiter_if.slave (en/req/data in; ack/busy/grant_id/
//           tbuf_i/tbuf_oen out, all registered)
// Optional feature: define TLVDS_ARB_PARITY_EN to add the parity bit.
module tlvds_tx_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 2,
    parameter int unsigned GUARD = 2
) (
    input logic              clk,
    input logic              rst_n,
    tlvds_tx_arbiter_if.slave bus
);
    localparam int unsigned IDW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BW         = $clog2(WIDTH + 1);
    localparam logic [7:0]  DIV_LOAD   = 8'(DIV - 1);
    localparam logic [7:0]  GUARD_LOAD = 8'(GUARD - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_GUARD
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         div_q, div_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               tbuf_i_q, tbuf_i_d;
    logic               tbuf_oen_q, tbuf_oen_d;
`ifdef TLVDS_ARB_PARITY_EN
    logic               par_q, par_d;
`endif

    logic [WIDTH-1:0]   word [NREQ];
    logic               found;
    logic [IDW-1:0]     sel;
    int unsigned        idx;

    // Unpack the flattened payload bus.
    always_comb begin
        for (int unsigned k = 0; k < NREQ; k++) begin
            word[k] = bus.data[k*WIDTH +: WIDTH];
        end
    end

    // First pending requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && bus.req[IDW'(idx)]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    // Next state, counters and registered pad/handshake values.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        ack_d      = '0;
        busy_d     = busy_q;
        tbuf_i_d   = 1'b0;
        tbuf_oen_d = 1'b1;
`ifdef TLVDS_ARB_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.en && found) begin
                    state_d    = S_START;
                    div_d      = DIV_LOAD;
                    bit_d      = '0;
                    shift_d    = word[sel];
                    ptr_d      = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
                    gid_d      = sel;
                    ack_d[sel] = 1'b1;
                    busy_d     = 1'b1;
`ifdef TLVDS_ARB_PARITY_EN
                    par_d      = ^word[sel];
`endif
                end
            end
            S_START: begin
                if (div_q == 8'd0) begin
                    state_d = S_DATA;
                    div_d   = DIV_LOAD;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            S_DATA: begin
                if (div_q == 8'd0) begin
                    if (bit_q == LAST_BIT) begin
`ifdef TLVDS_ARB_PARITY_EN
                        state_d = S_PAR;
                        div_d   = DIV_LOAD;
`else
                        if (GUARD == 0) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_GUARD;
                            div_d   = GUARD_LOAD;
                        end
`endif
                    end else begin
                        shift_d = shift_q << 1;
                        bit_d   = bit_q + BW'(1);
                        div_d   = DIV_LOAD;
                    end
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
`ifdef TLVDS_ARB_PARITY_EN
            S_PAR: begin
                if (div_q == 8'd0) begin
                    if (GUARD == 0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_GUARD;
                        div_d   = GUARD_LOAD;
                    end
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
`endif
            S_GUARD: begin
                if (div_q == 8'd0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Pad value follows the state being entered so it is registered.
        case (state_d)
            S_START: begin
                tbuf_i_d   = 1'b1;
                tbuf_oen_d = 1'b0;
            end
            S_DATA: begin
                tbuf_i_d   = shift_d[WIDTH-1];
                tbuf_oen_d = 1'b0;
            end
`ifdef TLVDS_ARB_PARITY_EN
            S_PAR: begin
                tbuf_i_d   = par_d;
                tbuf_oen_d = 1'b0;
            end
`endif
            default: begin
                tbuf_i_d   = 1'b0;
                tbuf_oen_d = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            gid_q      <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            tbuf_i_q   <= 1'b0;
            tbuf_oen_q <= 1'b1;
`ifdef TLVDS_ARB_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            tbuf_i_q   <= tbuf_i_d;
            tbuf_oen_q <= tbuf_oen_d;
`ifdef TLVDS_ARB_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = gid_q;
    assign bus.tbuf_i   = tbuf_i_q;
    assign bus.tbuf_oen = tbuf_oen_q;
endmodule

// File: tb/tb_tlvds_tx_arbiter.sv
// Directed bench for tlvds_tx_arbiter: default instance (4 req, 8 bit,
// DIV=2, GUARD=2) and an edge instance (2 req, 1 bit, DIV=1, GUARD=0).
module tb_tlvds_tx_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DIV   = 2;
    localparam int GUARD = 2;
`ifdef TLVDS_ARB_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int DW   = DIV * (1 + WIDTH + P);
    localparam int PER  = DW + GUARD + 1;
    localparam int EPER = 1 * (1 + 1 + P) + 0 + 1;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    tlvds_tx_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bif();
    tlvds_tx_arbiter_if #(.NREQ(2), .WIDTH(1)) eif();

    tlvds_tx_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DIV(DIV), .GUARD(GUARD)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    tlvds_tx_arbiter #(.NREQ(2), .WIDTH(1), .DIV(1), .GUARD(0)) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (eif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame bit b: 0 = start, 1..8 = data MSB-first, 9 = even parity.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b1;
        if (b <= 8) return d[8-b];
        return ^d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single grant of requester id carrying d; checks every cycle of the frame.
    task automatic run_frame(input int id, input logic [7:0] d);
        logic [2:0] exp;
        bif.data = '0;
        bif.data[id*WIDTH +: WIDTH] = d;
        bif.req  = 4'(1 << id);
        @(negedge clk);
        chk($sformatf("ack_r%0d", id), 32'(bif.ack), 32'(1 << id));
        chk($sformatf("gid_r%0d", id), 32'(bif.grant_id), 32'(id));
        bif.req = '0;
        for (int c = 0; c < DW + GUARD + 2; c++) begin
            if (c > 0) @(negedge clk);
            if (c < DW)              exp = {1'b1, 1'b0, exp_bit(d, c / DIV)};
            else if (c < DW + GUARD) exp = {1'b1, 1'b1, 1'b0};
            else                     exp = {1'b0, 1'b1, 1'b0};
            chk($sformatf("frame_r%0d_c%0d{busy,oen,i}", id, c),
                32'({bif.busy, bif.tbuf_oen, bif.tbuf_i}), 32'(exp));
            if (c == 1) chk("ack_pulse_width", 32'(bif.ack), 32'd0);
        end
    endtask

    initial begin
        int n_ack;
        int ack_id [8];
        int ack_cyc [8];
        int viol;
        logic [3:0] e_exp;
        int ph;
        int eid;

        n_total  = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        bif.en   = 1'b0;
        bif.req  = '0;
        bif.data = '0;
        eif.en   = 1'b0;
        eif.req  = '0;
        eif.data = '0;
        repeat (2) @(negedge clk);

        chk("rst_oen",  32'(bif.tbuf_oen), 32'd1);
        chk("rst_i",    32'(bif.tbuf_i),   32'd0);
        chk("rst_ack",  32'(bif.ack),      32'd0);
        chk("rst_busy", 32'(bif.busy),     32'd0);
        chk("rst_gid",  32'(bif.grant_id), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requests (second one exercises the parity case when compiled in).
        bif.en = 1'b1;
        run_frame(1, 8'hA5);
        run_frame(2, 8'h07);

        // Round robin with all requests held.
        do_reset();
        bif.req  = 4'b1111;
        bif.data = 32'h11223344;
        n_ack = 0;
        for (int c = 1; c <= 84; c++) begin
            @(negedge clk);
            if (bif.ack != '0) begin
                if (n_ack < 8) begin
                    ack_cyc[n_ack] = c;
                    ack_id[n_ack]  = 0;
                    for (int k = 0; k < NREQ; k++) if (bif.ack[k]) ack_id[n_ack] = k;
                end
                chk($sformatf("rr_onehot%0d", n_ack), 32'($onehot(bif.ack)), 32'd1);
                n_ack++;
            end
        end
        chk("rr_count", 32'(n_ack), 32'd4);
        for (int k = 0; k < 4 && k < n_ack; k++) begin
            chk($sformatf("rr_id%0d", k), 32'(ack_id[k]), 32'(k));
            if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(ack_cyc[k] - ack_cyc[k-1]), 32'(PER));
        end
        bif.req = '0;

        // Enable drop five cycles into a frame.
        do_reset();
        bif.en  = 1'b1;
        bif.req = 4'b1111;
        n_ack = 0;
        viol  = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bif.ack != '0) n_ack++;
            if (c >= DW + GUARD && bif.tbuf_oen !== 1'b1) viol++;
            if (c == DW + GUARD - 1) chk("endrop_busy_tail", 32'(bif.busy), 32'd1);
            if (c == DW + GUARD)     chk("endrop_busy_fall", 32'(bif.busy), 32'd0);
            if (c == 5) bif.en = 1'b0;
        end
        chk("endrop_acks", 32'(n_ack), 32'd1);
        chk("endrop_oen_viol", 32'(viol), 32'd0);
        bif.req = '0;

        // Reset during data bit 3.
        do_reset();
        bif.en   = 1'b1;
        bif.data = '0;
        bif.data[2*WIDTH +: WIDTH] = 8'hFF;
        bif.req  = 4'b0100;
        @(negedge clk);
        chk("mid_ack", 32'(bif.ack), 32'b0100);
        bif.req = '0;
        repeat (4 * DIV) @(negedge clk);
        chk("mid_driving", 32'({bif.tbuf_oen, bif.tbuf_i}), 32'b01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oen",  32'(bif.tbuf_oen), 32'd1);
        chk("mid_rst_busy", 32'(bif.busy),     32'd0);
        chk("mid_rst_ack",  32'(bif.ack),      32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        bif.req = 4'b1111;
        @(negedge clk);
        chk("post_rst_ack", 32'(bif.ack),      32'b0001);
        chk("post_rst_gid", 32'(bif.grant_id), 32'd0);
        bif.req = '0;
        bif.en  = 1'b0;

        // Edge instance: alternating grants, IDLE tristate between frames.
        eif.en   = 1'b1;
        eif.data = 2'b01;
        eif.req  = 2'b11;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            ph  = c % EPER;
            eid = (c / EPER) % 2;
            if (ph == 0)             e_exp = {2'(1 << eid), 1'b0, 1'b1};
            else if (ph == EPER - 1) e_exp = {2'b00, 1'b1, 1'b0};
            else                     e_exp = {2'b00, 1'b0, (eid == 0) ? 1'b1 : 1'b0};
            chk($sformatf("edge_c%0d{ack,oen,i}", c),
                32'({eif.ack, eif.tbuf_oen, eif.tbuf_i}), 32'(e_exp));
        end
        eif.req = '0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/tlvds_tx_arbiter.md
# tlvds_tx_arbiter

Round-robin scheduler that shares one TLVDS_TBUF tristate differential output pair between several on-chip requesters. Each granted requester gets one serial frame on the pair: a start bit, data MSB-first, and an optional parity bit, followed by a tristated guard gap for bus turnaround. The block drives the TLVDS_TBUF `I` and `OEN` pins directly and sits between the requester logic and the I/O primitive in the top level.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `WIDTH`, 8: data bits per frame (1..32)
- `DIV`, 2: clock cycles per serial bit (1..255)
- `GUARD`, 2: tristated turnaround cycles after each frame (0..15)

- `clk`  in  1  sole clock; all logic on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  enables new grants; an in-flight frame always completes
- `req`  in  NREQ  per-requester request level; held until the matching `ack`
- `data`  in  NREQ*WIDTH  flattened payloads; requester k occupies bits [k*WIDTH +: WIDTH]
- `ack`  out  NREQ  one-cycle pulse marking the grant, one-hot
- `busy`  out  1  high from the grant until the guard gap ends
- `grant_id`  out  $clog2(NREQ)  index of the last granted requester
- `tbuf_i`  out  1  to TLVDS_TBUF `I`
- `tbuf_oen`  out  1  to TLVDS_TBUF `OEN` (low = driving)

## Operation
- FSM states: IDLE, START, DATA, PAR, GUARD.
- IDLE: `tbuf_oen`=1 and `tbuf_i`=0. If `en`=1 and any `req` bit is set, select the first requester at or after `ptr`, wrapping modulo NREQ. Latch its data into the shift register. On the next edge, go to START, set `ptr` = selected+1 (wrapping), and update `grant_id`.
- START: `tbuf_oen`=0 and `tbuf_i`=1 for DIV cycles.
- DATA: `tbuf_oen`=0. Shift out WIDTH bits MSB-first, each bit held DIV cycles.
- PAR: present only with the macro (see Configuration).
- GUARD: `tbuf_oen`=1 and `tbuf_i`=0 for GUARD cycles. If GUARD=0, go straight to IDLE.
- Bit counter: $clog2(WIDTH+1) bits. Divider counter: 8 bits; reloads to DIV-1 and counts down to 0.
- `req` and `data` are ignored outside IDLE. A `req` deasserted before its `ack` is simply not granted.
- A requester that holds `req` high continuously is re-granted only after every other pending requester has had one frame.
- `en` falling mid-frame: the frame and its guard gap complete, then the FSM stays in IDLE.
- Reset at any time: all state returns to reset values immediately (asynchronous), and the pad goes tristate at once.

## Timing
- Reset values:
  - `tbuf_oen`=1, `tbuf_i`=0
  - `ack`=0, `busy`=0, `grant_id`=0
  - `ptr`=0, FSM=IDLE
- All outputs are registered.
- Grant latency: `req` sampled high in IDLE at edge t. At t+1, `ack` is pulsed, `busy`=1, and the START bit is on the pad.
- Drive window: DIV*(1+WIDTH+P) cycles, where P=1 if parity is compiled in, else 0. This is followed by GUARD tristated cycles.
- `busy` falls on the edge that re-enters IDLE.
- IDLE lasts at least one cycle. Back-to-back frame period is DIV*(1+WIDTH+P)+GUARD+1 cycles.

## Configuration
- `TLVDS_ARB_PARITY_EN` defined:
  - PAR state follows DATA and drives the even parity of the latched word (XOR of all data bits) for DIV cycles, with `tbuf_oen`=0.
- Undefined:
  - PAR state and parity logic are absent; DATA goes directly to GUARD.

## Test plan
Defaults (NREQ=4, WIDTH=8, DIV=2, GUARD=2) unless stated otherwise.
- Single request, macro off: `req`=4'b0010, requester 1 data=8'hA5.
  - `ack`=4'b0010 one cycle later.
  - Pad drives 1,1,0,1,0,0,1,0,1 (each bit held 2 cycles), then is tristate for 2 cycles.
  - `busy` high for exactly 20 cycles. `grant_id`=1.
- Round robin: all `req` held at 4'b1111 for 84 cycles from reset.
  - `ack` sequence is 0,1,2,3, with successive grants spaced 21 cycles apart.
- Parity, macro on: data=8'h07.
  - Parity bit = 1, drive window = 20 cycles, period = 23 cycles.
- Enable drop: deassert `en` 5 cycles into a frame while `req`=4'b1111.
  - The frame and its guard gap complete, then `tbuf_oen` stays 1 and no further `ack` is issued.
- Reset mid-DATA: pull `rst_n` low during bit 3.
  - `tbuf_oen`=1, `busy`=0, `ack`=0 in the same cycle.
  - After release, the first grant goes to requester 0.
- Edge parameters: DIV=1, GUARD=0, WIDTH=1, two requesters.
  - Period is 3 cycles.
  - The pad is never driven in two consecutive frames without at least one IDLE tristate cycle between them.
